// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall, bubble and forward-ready flag
module pipe_stage_reg #(
  parameter int          PAYLOAD_W     = 96,
  parameter int          TNEW_W        = 2,
  parameter int          EXC_W         = 5,
  parameter logic [31:0] PC_RESET      = 32'h0000_3000,
  parameter bit          DEC_TNEW      = 1'b1,
  parameter bit          FLUSH_KEEP_PC = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_a3,
  input  logic                 in_rfwr,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic                 in_bd,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_a3,
  output logic                 out_rfwr,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [EXC_W-1:0]     out_exc,
  output logic                 out_bd,
  output logic                 out_fwd_ok
);

  localparam logic [TNEW_W-1:0] TNEW_ONE = {{(TNEW_W-1){1'b0}}, 1'b1};

  logic [TNEW_W-1:0] load_tnew;

  // Tnew counts down one stage per hop; it saturates at zero so a produced result stays produced
  always_comb begin
    load_tnew = in_tnew;
    if (DEC_TNEW && (in_tnew != '0)) begin
      load_tnew = in_tnew - TNEW_ONE;
    end
  end

  // Stage register: reset beats flush, flush beats hold, hold beats load
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= PC_RESET;
      out_payload <= '0;
      out_a3      <= 5'd0;
      out_rfwr    <= 1'b0;
      out_tnew    <= '0;
      out_exc     <= '0;
      out_bd      <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_a3      <= 5'd0;
      out_rfwr    <= 1'b0;
      out_tnew    <= '0;
      out_exc     <= '0;
      // Bubbles may carry the flushed slot's PC/BD so EPC stays meaningful downstream
      out_pc      <= FLUSH_KEEP_PC ? in_pc : PC_RESET;
      out_bd      <= FLUSH_KEEP_PC ? in_bd : 1'b0;
    end else if (en) begin
      out_valid   <= in_valid;
      out_pc      <= in_pc;
      out_payload <= in_payload;
      // An empty slot must never write the register file nor be a forwarding source
      out_a3      <= in_valid ? in_a3 : 5'd0;
      out_rfwr    <= in_valid & in_rfwr;
      out_tnew    <= load_tnew;
      out_exc     <= in_exc;
      out_bd      <= in_bd;
    end
  end

  // Forward-ready is decoded from registered state only, so it adds no input-to-output path
  always_comb begin
    out_fwd_ok = out_valid & out_rfwr & (out_a3 != 5'd0) & (out_tnew == '0);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic        in_valid, in_rfwr, in_bd;
  logic [31:0] in_pc;
  logic [95:0] in_payload;
  logic [4:0]  in_a3, in_exc;
  logic [1:0]  in_tnew;

  logic        o0_valid, o0_rfwr, o0_bd, o0_fwd;
  logic [31:0] o0_pc;
  logic [95:0] o0_payload;
  logic [4:0]  o0_a3, o0_exc;
  logic [1:0]  o0_tnew;

  logic        o1_valid, o1_rfwr, o1_bd, o1_fwd;
  logic [31:0] o1_pc;
  logic [95:0] o1_payload;
  logic [4:0]  o1_a3, o1_exc;
  logic [1:0]  o1_tnew;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEC_TNEW(1'b1), .FLUSH_KEEP_PC(1'b1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload), .in_a3(in_a3),
    .in_rfwr(in_rfwr), .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(o0_valid), .out_pc(o0_pc), .out_payload(o0_payload), .out_a3(o0_a3),
    .out_rfwr(o0_rfwr), .out_tnew(o0_tnew), .out_exc(o0_exc), .out_bd(o0_bd),
    .out_fwd_ok(o0_fwd)
  );

  pipe_stage_reg #(.DEC_TNEW(1'b0), .FLUSH_KEEP_PC(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload), .in_a3(in_a3),
    .in_rfwr(in_rfwr), .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(o1_valid), .out_pc(o1_pc), .out_payload(o1_payload), .out_a3(o1_a3),
    .out_rfwr(o1_rfwr), .out_tnew(o1_tnew), .out_exc(o1_exc), .out_bd(o1_bd),
    .out_fwd_ok(o1_fwd)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [95:0] payload;
    logic [4:0]  a3;
    logic        rfwr;
    logic [1:0]  tnew;
    logic [4:0]  exc;
    logic        bd;
  } slot_t;

  slot_t m0, m1;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the stage should hold after one edge, stated from the operating rules
  function automatic slot_t model_next(slot_t cur, bit dec, bit keep);
    slot_t n;
    n = cur;
    if (reset) begin
      n = '0;
      n.pc = 32'h3000;
    end else if (flush) begin
      n = '0;
      n.pc = keep ? in_pc : 32'h3000;
      n.bd = keep ? in_bd : 1'b0;
    end else if (en) begin
      n.valid   = in_valid;
      n.pc      = in_pc;
      n.payload = in_payload;
      n.a3      = in_valid ? in_a3 : 5'd0;
      n.rfwr    = in_valid && in_rfwr;
      n.tnew    = (dec && in_tnew != 2'd0) ? 2'(int'(in_tnew) - 1) : in_tnew;
      n.exc     = in_exc;
      n.bd      = in_bd;
    end
    return n;
  endfunction

  function automatic logic fwd_of(slot_t s);
    return s.valid && s.rfwr && (s.a3 != 0) && (s.tnew == 0);
  endfunction

  // Advance one edge on both instances and compare them in full against the model
  task automatic step();
    m0 = model_next(m0, 1'b1, 1'b1);
    m1 = model_next(m1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("dut0_state",
             {16'd0, o0_valid, o0_pc, o0_payload, o0_a3, o0_rfwr, o0_tnew, o0_exc, o0_bd, o0_fwd},
             {16'd0, m0, fwd_of(m0)});
    check_eq("dut1_state",
             {16'd0, o1_valid, o1_pc, o1_payload, o1_a3, o1_rfwr, o1_tnew, o1_exc, o1_bd, o1_fwd},
             {16'd0, m1, fwd_of(m1)});
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                       input logic rfwr, input logic [1:0] tnew, input logic [4:0] exc,
                       input logic bd, input logic e, input logic f);
    in_valid = v; in_pc = pc; in_a3 = a3; in_rfwr = rfwr; in_tnew = tnew;
    in_exc = exc; in_bd = bd; en = e; flush = f;
    in_payload = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    m0 = '0;
    m1 = '0;
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEC, 5'd9, 1'b1, 2'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("reset_pc", {128'd0, o0_pc}, {128'd0, 32'h3000});
    check_eq("reset_valid_fwd", {158'd0, o0_valid, o0_fwd}, 160'd0);
    reset = 1'b0;

    drive(1'b1, 32'h3004, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("tnew2_dec", {158'd0, o0_tnew}, 160'd1);
    check_eq("tnew2_nofwd", {159'd0, o0_fwd}, 160'd0);
    check_eq("tnew2_nodec", {158'd0, o1_tnew}, 160'd2);
    drive(1'b1, 32'h3008, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("tnew1_dec", {158'd0, o0_tnew}, 160'd0);
    check_eq("tnew1_fwd", {159'd0, o0_fwd}, 160'd1);
    drive(1'b1, 32'h300C, 5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("tnew0_sat", {158'd0, o0_tnew}, 160'd0);
    drive(1'b1, 32'h300C, 5'd8, 1'b1, 2'd3, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("tnew3_dec", {158'd0, o0_tnew}, 160'd2);

    drive(1'b1, 32'h3010, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'($urandom), 1'b1, 2'($urandom), 5'($urandom), 1'b1, 1'b0, 1'b0);
      step();
      check_eq("stall_pc", {128'd0, o0_pc}, {128'd0, 32'h3010});
      check_eq("stall_tnew", {158'd0, o0_tnew}, 160'd1);
    end
    drive(1'b1, 32'h3014, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("release_pc", {128'd0, o0_pc}, {128'd0, 32'h3014});

    drive(1'b1, 32'h3020, 5'd5, 1'b1, 2'd0, 5'd4, 1'b1, 1'b0, 1'b1);
    step();
    check_eq("flush_keep", {120'd0, o0_valid, o0_rfwr, o0_a3, o0_pc, o0_bd},
             {120'd0, 1'b0, 1'b0, 5'd0, 32'h3020, 1'b1});
    check_eq("flush_nokeep", {120'd0, o1_valid, o1_rfwr, o1_a3, o1_pc, o1_bd},
             {120'd0, 1'b0, 1'b0, 5'd0, 32'h3000, 1'b0});
    check_eq("flush_exc", {155'd0, o0_exc}, 160'd0);

    drive(1'b0, 32'h3024, 5'd31, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("invalid_slot", {153'd0, o0_rfwr, o0_a3, o0_fwd}, 160'd0);
    drive(1'b1, 32'h3028, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("zero_dest", {159'd0, o0_fwd}, 160'd0);

    drive(1'b1, 32'h302C, 5'd2, 1'b1, 2'd0, 5'd4, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("exc_pass", {155'd0, o0_exc}, 160'd4);
    drive(1'b1, 32'h3030, 5'd2, 1'b1, 2'd0, 5'd4, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("exc_flushed", {155'd0, o0_exc}, 160'd0);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0, 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
